// File: rtl/isdu_pkg.sv
// Shared state encoding, opcode values and datapath select encodings for the
// LC-3 subset instruction sequencing and decode unit.
package isdu_pkg;

  typedef enum logic [4:0] {
    HALTED, S_18, S_33, S_35, PAUSE_IR1, PAUSE_IR2, S_32,
    S_01, S_05, S_09, S_00, S_22, S_12, S_04, S_21,
    S_06, S_25, S_27, S_07, S_23, S_16, PAUSE_1, PAUSE_2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  function automatic logic is_mem_wait(input state_t s);
    return (s == S_33) || (s == S_25) || (s == S_16);
  endfunction

endpackage

// File: rtl/isdu_control_mem_wait_counter.sv
// Fixed-latency memory wait counter; done is high on the last cycle of a wait.
module mem_wait_counter #(
  parameter int MEM_WAIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  logic [2:0] count_reg;

  assign done = enable && (count_reg == LAST);

  // Wrapping to zero on done keeps the counter ready for the next wait state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 3'd0;
    end else if (clear || done) begin
      count_reg <= 3'd0;
    end else if (enable) begin
      count_reg <= count_reg + 3'd1;
    end
  end

endmodule

// File: rtl/isdu_control.sv
// Moore control FSM sequencing fetch/decode/execute for the LC-3 subset and
// driving all datapath loads, gates, mux selects and active-low SRAM strobes.
module isdu_control
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
  output logic       GatePC, GateMDR, GateALU, GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
);

  state_t state_reg, state_next;
  logic   wait_en, wait_done;

  assign wait_en = is_mem_wait(state_reg);

  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk    (Clk),
    .rst_n  (Reset),
    .clear  (~wait_en),
    .enable (wait_en),
    .done   (wait_done)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_reg <= HALTED;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC  = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PCMUX_INC; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_ZERO; ALUK = ALUK_ADD; MIO_EN = 1'b0;
    // Chip and byte enables are held active whenever the machine is running.
    Mem_CE = (state_reg == HALTED);
    Mem_UB = (state_reg == HALTED);
    Mem_LB = (state_reg == HALTED);
    Mem_OE = 1'b1;
    Mem_WE = 1'b1;

    case (state_reg)
      HALTED: if (Run) state_next = S_18;
      S_18: begin
        GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_INC;
        state_next = S_33;
      end
      S_33, S_25: begin
        Mem_OE = 1'b0; MIO_EN = 1'b1; LD_MDR = wait_done;
        if (wait_done) state_next = (state_reg == S_33) ? S_35 : S_27;
      end
      S_35: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
        state_next = PAUSE_IR1;
      end
      PAUSE_IR1: begin
        LD_LED = 1'b1;
        if (Continue) state_next = PAUSE_IR2;
      end
      PAUSE_IR2: if (!Continue) state_next = S_32;
      S_32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          OP_ADD:   state_next = S_01;
          OP_AND:   state_next = S_05;
          OP_NOT:   state_next = S_09;
          OP_BR:    state_next = S_00;
          OP_JMP:   state_next = S_12;
          OP_JSR:   state_next = S_04;
          OP_LDR:   state_next = S_06;
          OP_STR:   state_next = S_07;
          OP_PAUSE: state_next = PAUSE_1;
          default:  state_next = S_18;
        endcase
      end
      S_01, S_05: begin
        ALUK = (state_reg == S_01) ? ALUK_ADD : ALUK_AND;
        SR1MUX = 1'b1; SR2MUX = IR_5;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        state_next = S_18;
      end
      S_09: begin
        ALUK = ALUK_NOT; SR1MUX = 1'b1;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        state_next = S_18;
      end
      S_00: state_next = BEN ? S_22 : S_18;
      S_22: begin
        ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
        state_next = S_18;
      end
      S_12: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
        state_next = S_18;
      end
      S_04: begin
        GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
        state_next = S_21;
      end
      S_21: begin
        if (IR_11) begin
          ADDR2MUX = ADDR2_OFF11;
        end else begin
          ADDR1MUX = 1'b1; SR1MUX = 1'b1;
        end
        PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
        state_next = S_18;
      end
      S_06, S_07: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF6;
        GateMARMUX = 1'b1; LD_MAR = 1'b1;
        state_next = (state_reg == S_06) ? S_25 : S_23;
      end
      S_27: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        state_next = S_18;
      end
      S_23: begin
        ALUK = ALUK_PASS; GateALU = 1'b1; LD_MDR = 1'b1;
        state_next = S_16;
      end
      S_16: begin
        Mem_WE = 1'b0;
        if (wait_done) state_next = S_18;
      end
      PAUSE_1: begin
        LD_LED = 1'b1;
        if (Continue) state_next = PAUSE_2;
      end
      PAUSE_2: if (!Continue) state_next = S_18;
      default: state_next = HALTED;
    endcase
  end

endmodule

// File: tb/tb_isdu_control.sv
// Directed, table-driven check of the isdu_control output sequence, plus
// hand-written reset-abort and single-cycle memory wait sequences.
module tb_isdu_control;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic mio_en, ce, ub, lb, oe, we;
  } ctl_t;

  typedef struct packed {
    logic       run, cont;
    logic [3:0] opc;
    logic       ir5, ir11, ben;
    ctl_t       exp;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset, Run, Continue, IR_5, IR_11, BEN, run1;
  logic [3:0] Opcode;
  wire [27:0] o0, o1;
  ctl_t act0, act1;
  assign act0 = o0;
  assign act1 = o1;

  always #5 Clk = ~Clk;

  isdu_control #(.MEM_WAIT(3)) u_dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(o0[27]), .LD_MDR(o0[26]), .LD_IR(o0[25]), .LD_BEN(o0[24]),
    .LD_CC(o0[23]), .LD_REG(o0[22]), .LD_PC(o0[21]), .LD_LED(o0[20]),
    .GatePC(o0[19]), .GateMDR(o0[18]), .GateALU(o0[17]), .GateMARMUX(o0[16]),
    .PCMUX(o0[15:14]), .DRMUX(o0[13]), .SR1MUX(o0[12]), .SR2MUX(o0[11]),
    .ADDR1MUX(o0[10]), .ADDR2MUX(o0[9:8]), .ALUK(o0[7:6]), .MIO_EN(o0[5]),
    .Mem_CE(o0[4]), .Mem_UB(o0[3]), .Mem_LB(o0[2]), .Mem_OE(o0[1]), .Mem_WE(o0[0])
  );

  isdu_control #(.MEM_WAIT(1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Run(run1), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(o1[27]), .LD_MDR(o1[26]), .LD_IR(o1[25]), .LD_BEN(o1[24]),
    .LD_CC(o1[23]), .LD_REG(o1[22]), .LD_PC(o1[21]), .LD_LED(o1[20]),
    .GatePC(o1[19]), .GateMDR(o1[18]), .GateALU(o1[17]), .GateMARMUX(o1[16]),
    .PCMUX(o1[15:14]), .DRMUX(o1[13]), .SR1MUX(o1[12]), .SR2MUX(o1[11]),
    .ADDR1MUX(o1[10]), .ADDR2MUX(o1[9:8]), .ALUK(o1[7:6]), .MIO_EN(o1[5]),
    .Mem_CE(o1[4]), .Mem_UB(o1[3]), .Mem_LB(o1[2]), .Mem_OE(o1[1]), .Mem_WE(o1[0])
  );

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];
  logic [3:0] cur_opc;
  logic cur_ir5, cur_ir11, cur_ben;

  ctl_t e_halt, e_act, e_s18, e_s33, e_s33l, e_s35, e_led, e_s32;
  ctl_t e_add1, e_and0, e_not, e_s22, e_jmp, e_s07, e_s23, e_s16;
  ctl_t e_s04, e_s21r, e_s21j, e_s27;

  task automatic check(input string name, input ctl_t act, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic add(input logic run, input logic cont, input ctl_t e);
    vec_t v;
    v.run = run; v.cont = cont; v.opc = cur_opc;
    v.ir5 = cur_ir5; v.ir11 = cur_ir11; v.ben = cur_ben; v.exp = e;
    vecs.push_back(v);
  endtask

  // From S_18: three-cycle read, IR load, pause with Continue held, then decode.
  task automatic fetch(input logic [3:0] opc, input logic ir5, input logic ir11,
                       input logic ben);
    cur_opc = opc; cur_ir5 = ir5; cur_ir11 = ir11; cur_ben = ben;
    add(0, 0, e_s33); add(0, 0, e_s33); add(0, 0, e_s33l); add(0, 0, e_s35);
    add(0, 0, e_led); add(0, 1, e_act); add(0, 1, e_act); add(0, 0, e_s32);
  endtask

  initial begin
    Reset = 1'b0; Run = 1'b0; Continue = 1'b0; Opcode = 4'h0;
    IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0; run1 = 1'b0;

    e_halt = '0; e_halt.ce = 1; e_halt.ub = 1; e_halt.lb = 1; e_halt.oe = 1; e_halt.we = 1;
    e_act = '0; e_act.oe = 1; e_act.we = 1;
    e_s18 = e_act; e_s18.gate_pc = 1; e_s18.ld_mar = 1; e_s18.ld_pc = 1;
    e_s33 = e_act; e_s33.oe = 0; e_s33.mio_en = 1;
    e_s33l = e_s33; e_s33l.ld_mdr = 1;
    e_s35 = e_act; e_s35.gate_mdr = 1; e_s35.ld_ir = 1;
    e_led = e_act; e_led.ld_led = 1;
    e_s32 = e_act; e_s32.ld_ben = 1;
    e_add1 = e_act; e_add1.sr1mux = 1; e_add1.sr2mux = 1; e_add1.gate_alu = 1;
    e_add1.ld_reg = 1; e_add1.ld_cc = 1; e_add1.aluk = 2'b00;
    e_and0 = e_add1; e_and0.sr2mux = 0; e_and0.aluk = 2'b01;
    e_not = e_add1; e_not.sr2mux = 0; e_not.aluk = 2'b10;
    e_s22 = e_act; e_s22.addr2mux = 2'b10; e_s22.pcmux = 2'b10; e_s22.ld_pc = 1;
    e_jmp = e_act; e_jmp.sr1mux = 1; e_jmp.addr1mux = 1; e_jmp.pcmux = 2'b10; e_jmp.ld_pc = 1;
    e_s07 = e_act; e_s07.sr1mux = 1; e_s07.addr1mux = 1; e_s07.addr2mux = 2'b01;
    e_s07.gate_marmux = 1; e_s07.ld_mar = 1;
    e_s23 = e_act; e_s23.aluk = 2'b11; e_s23.gate_alu = 1; e_s23.ld_mdr = 1;
    e_s16 = e_act; e_s16.we = 0;
    e_s04 = e_act; e_s04.gate_pc = 1; e_s04.drmux = 1; e_s04.ld_reg = 1;
    e_s21r = e_jmp;
    e_s21j = e_act; e_s21j.addr2mux = 2'b11; e_s21j.pcmux = 2'b10; e_s21j.ld_pc = 1;
    e_s27 = e_act; e_s27.gate_mdr = 1; e_s27.ld_reg = 1; e_s27.ld_cc = 1;

    cur_opc = 4'h0; cur_ir5 = 0; cur_ir11 = 0; cur_ben = 0;
    add(1, 0, e_s18);
    fetch(4'b0001, 1, 0, 0); add(1, 0, e_add1); add(0, 0, e_s18);
    fetch(4'b0000, 0, 0, 0); add(1, 0, e_act); add(0, 0, e_s18);
    fetch(4'b0000, 0, 0, 1); add(0, 0, e_act); add(0, 0, e_s22); add(0, 0, e_s18);
    fetch(4'b0111, 0, 0, 0); add(0, 0, e_s07); add(0, 0, e_s23);
    add(0, 0, e_s16); add(0, 0, e_s16); add(0, 0, e_s16); add(0, 0, e_s18);
    fetch(4'b0100, 0, 0, 0); add(0, 0, e_s04); add(0, 0, e_s21r); add(0, 0, e_s18);
    fetch(4'b0100, 0, 1, 0); add(0, 0, e_s04); add(0, 0, e_s21j); add(0, 0, e_s18);
    fetch(4'b0101, 0, 0, 0); add(0, 0, e_and0); add(0, 0, e_s18);
    fetch(4'b1001, 0, 0, 0); add(0, 0, e_not); add(0, 0, e_s18);
    fetch(4'b1100, 0, 0, 0); add(0, 0, e_jmp); add(0, 0, e_s18);
    fetch(4'b0110, 0, 0, 0); add(0, 0, e_s07); add(0, 0, e_s33); add(0, 0, e_s33);
    add(0, 0, e_s33l); add(0, 0, e_s27); add(0, 0, e_s18);
    fetch(4'b1101, 0, 0, 0); add(0, 0, e_led); add(0, 1, e_act); add(0, 1, e_act);
    add(0, 0, e_s18);
    fetch(4'b1111, 0, 0, 0); add(0, 0, e_s18);

    repeat (2) @(posedge Clk);
    #1;
    check("reset_low", act0, e_halt);
    check("reset_low_dut1", act1, e_halt);
    @(negedge Clk); Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      check($sformatf("idle_halted%0d", i), act0, e_halt);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      Run = vecs[i].run; Continue = vecs[i].cont; Opcode = vecs[i].opc;
      IR_5 = vecs[i].ir5; IR_11 = vecs[i].ir11; BEN = vecs[i].ben;
      @(posedge Clk); #1;
      check($sformatf("row%0d", i), act0, vecs[i].exp);
    end

    // Reset in the middle of a memory read must release the strobes at once.
    @(negedge Clk); Run = 1'b0; Continue = 1'b0;
    @(posedge Clk); #1;
    check("s33_before_reset", act0, e_s33);
    #2 Reset = 1'b0;
    #1 check("reset_mid_wait", act0, e_halt);
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    check("halted_after_abort", act0, e_halt);

    // MEM_WAIT=1: the read wait is a single cycle with LD_MDR asserted.
    @(negedge Clk); run1 = 1'b1;
    @(posedge Clk); #1; check("mw1_s18", act1, e_s18);
    @(negedge Clk); run1 = 1'b0;
    @(posedge Clk); #1; check("mw1_s33", act1, e_s33l);
    @(posedge Clk); #1; check("mw1_s35", act1, e_s35);
    @(posedge Clk); #1; check("mw1_pause", act1, e_led);
    @(posedge Clk); #1; check("mw1_pause_hold", act1, e_led);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
